usb_tx_serializer: RTL

- Upstream feeder for the NRZI/bit-stuff line encoder in the USB FS transmit path.
- Takes a byte stream (PID first, then payload bytes) and serialises it LSB-first onto the encoder's bit_in / last_bit / bit_ack handshake.
- Optionally appends the inverted USB CRC16 after the payload.
- Issues start_txn to the encoder and waits for the encoder's done pulse before accepting the next packet.

---
 rtl/usb_tx_serializer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_serializer.sv
// Byte-to-bit feeder for the USB FS NRZI/bit-stuff encoder: PID, payload and optional
// inverted CRC16 are shifted out LSB-first on the encoder's bit/ack handshake.
module usb_tx_serializer #(
  parameter int MAX_PAYLOAD = 1023
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       crc16_en,
  output logic       enc_start_txn,
  output logic       enc_bit,
  output logic       enc_last_bit,
  input  logic       enc_bit_ack,
  input  logic       enc_done,
  output logic       busy,
  output logic       err_underrun,
  output logic       err_overflow
);

  // WAIT_DONE shares DRAIN's encoding: DRAIN already holds last_bit until done.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_CRC_LO    = 3'd3;
  localparam logic [2:0] S_CRC_HI    = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = S_DRAIN;

  localparam logic [9:0]  MAX_CNT  = 10'(MAX_PAYLOAD);
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  logic [2:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] crc_q, crc_d;
  logic        crc_en_q, crc_en_d;
  logic        last_q, last_d;
  logic        pid_q, pid_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic        enc_bit_q, enc_bit_d;
  logic        busy_q, busy_d;
  logic        err_underrun_q, err_underrun_d;
  logic        err_overflow_q, err_overflow_d;
  logic        in_ready_c;
  logic [15:0] crc_nx;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
  endfunction

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_idx_d      = bit_idx_q;
    crc_d          = crc_q;
    crc_en_d       = crc_en_q;
    last_d         = last_q;
    pid_d          = pid_q;
    byte_cnt_d     = byte_cnt_q;
    enc_bit_d      = enc_bit_q;
    busy_d         = busy_q;
    err_underrun_d = err_underrun_q;
    err_overflow_d = err_overflow_q;
    in_ready_c     = 1'b0;
    // The PID is sent but never folded into the CRC.
    crc_nx         = pid_q ? crc_q : crc16_step(crc_q, shift_q[bit_idx_q]);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_c     = 1'b1;
          shift_d        = in_data;
          last_d         = in_last;
          pid_d          = 1'b1;
          crc_en_d       = crc16_en;
          crc_d          = CRC_INIT;
          byte_cnt_d     = 10'd0;
          err_underrun_d = 1'b0;
          err_overflow_d = 1'b0;
          busy_d         = 1'b1;
          state_d        = S_START;
        end
      end

      S_START: begin
        enc_bit_d = shift_q[0];
        bit_idx_d = 3'd0;
        state_d   = S_DATA;
      end

      S_DATA: begin
        if (enc_bit_ack) begin
          crc_d = crc_nx;
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            enc_bit_d = shift_q[bit_idx_q + 3'd1];
          end else if (last_q || (in_valid && byte_cnt_q == MAX_CNT)) begin
            err_overflow_d = err_overflow_q | ~last_q;
            if (crc_en_q) begin
              shift_d   = ~crc_nx[7:0];
              bit_idx_d = 3'd0;
              enc_bit_d = ~crc_nx[0];
              state_d   = S_CRC_LO;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (in_valid) begin
            in_ready_c = 1'b1;
            shift_d    = in_data;
            last_d     = in_last;
            pid_d      = 1'b0;
            byte_cnt_d = byte_cnt_q + 10'd1;
            bit_idx_d  = 3'd0;
            enc_bit_d  = in_data[0];
          end else begin
            err_underrun_d = 1'b1;
            state_d        = S_DRAIN;
          end
        end
      end

      S_CRC_LO: begin
        if (enc_bit_ack) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            enc_bit_d = shift_q[bit_idx_q + 3'd1];
          end else begin
            shift_d   = ~crc_q[15:8];
            bit_idx_d = 3'd0;
            enc_bit_d = ~crc_q[8];
            state_d   = S_CRC_HI;
          end
        end
      end

      S_CRC_HI: begin
        if (enc_bit_ack) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            enc_bit_d = shift_q[bit_idx_q + 3'd1];
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_WAIT_DONE: begin
        if (enc_done) begin
          busy_d  = 1'b0;
          crc_d   = CRC_INIT;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      shift_q        <= 8'h00;
      bit_idx_q      <= 3'd0;
      crc_q          <= CRC_INIT;
      crc_en_q       <= 1'b0;
      last_q         <= 1'b0;
      pid_q          <= 1'b0;
      byte_cnt_q     <= 10'd0;
      enc_bit_q      <= 1'b0;
      busy_q         <= 1'b0;
      err_underrun_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_idx_q      <= bit_idx_d;
      crc_q          <= crc_d;
      crc_en_q       <= crc_en_d;
      last_q         <= last_d;
      pid_q          <= pid_d;
      byte_cnt_q     <= byte_cnt_d;
      enc_bit_q      <= enc_bit_d;
      busy_q         <= busy_d;
      err_underrun_q <= err_underrun_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign in_ready      = in_ready_c & reset;
  assign enc_start_txn = (state_q == S_START);
  assign enc_last_bit  = (state_q == S_DRAIN);
  assign enc_bit       = enc_bit_q;
  assign busy          = busy_q;
  assign err_underrun  = err_underrun_q;
  assign err_overflow  = err_overflow_q;

endmodule
